// File: rtl/drac_pkg.sv
// Shared types and constants for the instruction-memory refill path.
//   refill_state_t       : refill initiator FSM states
//   IMEM_BEATS_PER_LINE  : response beats per cache line
//   IMEM_LINE_ADDR_W     : width of a 64-byte line address (byte address [31:6])
//   IMEM_BEAT_W          : width of one response beat
//   icache_fill_t        : one line fill as presented to the icache
package drac_pkg;

  localparam int unsigned IMEM_BEATS_PER_LINE = 4;
  localparam int unsigned IMEM_LINE_ADDR_W    = 26;
  localparam int unsigned IMEM_BEAT_W         = 128;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StFill
  } refill_state_t;

  typedef struct packed {
    logic                                       valid;
    logic [IMEM_LINE_ADDR_W-1:0]                addr;
    logic [IMEM_BEATS_PER_LINE*IMEM_BEAT_W-1:0] data;
  } icache_fill_t;

endpackage

// File: rtl/imem_refill_assembler.sv
// Four-slot beat buffer with arrival mask for one cache line.
//   clk, rstn : clock, synchronous active-low reset (clears the mask only)
//   clear     : drop all collected beats (new refill starting)
//   wr_en     : a beat is presented this cycle
//   keep      : store the beat data (otherwise only the mask is updated)
//   seq, data : beat index and payload
//   full      : mask including this cycle's beat covers all slots
//   dup       : the presented beat hits a slot that already arrived
//   line      : buffer contents with this cycle's beat merged in
module imem_refill_assembler
  import drac_pkg::*;
#(
  parameter int unsigned BeatW = IMEM_BEAT_W
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic                                 keep,
  input  logic [1:0]                           seq,
  input  logic [BeatW-1:0]                     data,
  output logic                                 full,
  output logic                                 dup,
  output logic [IMEM_BEATS_PER_LINE*BeatW-1:0] line
);

  logic [IMEM_BEATS_PER_LINE-1:0] mask_q, mask_d, hit, store;
  logic [BeatW-1:0]               slot_q [IMEM_BEATS_PER_LINE];

  always_comb begin
    hit = '0;
    if (wr_en) hit[seq] = 1'b1;
    dup    = |(hit & mask_q);
    // The first copy of a beat wins; duplicates never overwrite a slot.
    store  = keep ? (hit & ~mask_q) : '0;
    mask_d = mask_q | hit;
    full   = &mask_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask_q <= '0;
    end else if (clear) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IMEM_BEATS_PER_LINE; k++) begin
      if (store[k]) slot_q[k] <= data;
    end
  end

  // Write-through so the completing beat is visible in the same cycle.
  always_comb begin
    line = '0;
    for (int k = 0; k < IMEM_BEATS_PER_LINE; k++) begin
      line[k*BeatW +: BeatW] = store[k] ? data : slot_q[k];
    end
  end

endmodule

// File: rtl/imem_refill_initiator.sv
// Initiator side of the instruction-memory line refill: accepts one icache miss, issues a
// one-cycle line request, collects four tagged beats and delivers the line as a single fill.
//   clk_i, rstn_i                 : clock, synchronous active-low reset
//   miss_valid_i/addr_i/ready_o   : icache miss handshake
//   kill_i                        : abandon the in-flight refill
//   mem_req_valid_o/addr_o        : line request pulse to memory
//   mem_resp_valid_i/data_i/seq_i : response beats, any order
//   fill_valid_o/addr_o/data_o    : assembled line, one-cycle pulse; addr/data hold afterwards
//   err_o                         : pulse on timeout or duplicate beat
module imem_refill_initiator
  import drac_pkg::*;
#(
  parameter int unsigned LINE_SIZE      = 128,
  parameter int unsigned ADDR_SIZE      = 40,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   miss_valid_i,
  input  logic [ADDR_SIZE-1:0]   miss_addr_i,
  output logic                   miss_ready_o,
  input  logic                   kill_i,
  output logic                   mem_req_valid_o,
  output logic [25:0]            mem_req_addr_o,
  input  logic                   mem_resp_valid_i,
  input  logic [LINE_SIZE-1:0]   mem_resp_data_i,
  input  logic [1:0]             mem_resp_seq_i,
  output logic                   fill_valid_o,
  output logic [25:0]            fill_addr_o,
  output logic [4*LINE_SIZE-1:0] fill_data_o,
  output logic                   err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  refill_state_t                 state_q, state_d;
  logic [IMEM_LINE_ADDR_W-1:0]   line_addr_q, fill_addr_q;
  logic [4*LINE_SIZE-1:0]        fill_data_q, line;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          collecting, beat, accept, timeout, full, dup;
  icache_fill_t                  fill;

  // Only the line-address bits are used; the rest of the byte address is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{miss_addr_i[ADDR_SIZE-1:32], miss_addr_i[5:0]};

  assign collecting = (state_q == StWait) || (state_q == StDrain);
  assign beat       = collecting && mem_resp_valid_i;
  assign accept     = (state_q == StIdle) && miss_valid_i && !kill_i;
  // Fires on the TIMEOUT_CYCLES-th consecutive beat-less cycle.
  assign timeout    = collecting && !mem_resp_valid_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  imem_refill_assembler #(
    .BeatW (LINE_SIZE)
  ) u_assembler (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .clear (accept),
    .wr_en (beat),
    .keep  (state_q == StWait),
    .seq   (mem_resp_seq_i),
    .data  (mem_resp_data_i),
    .full  (full),
    .dup   (dup),
    .line  (line)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   state_d = kill_i ? StDrain : StWait;
      StWait: begin
        if (timeout)     state_d = StIdle;
        // A kill on the completing beat has nothing left to drain.
        else if (full)   state_d = kill_i ? StIdle : StFill;
        else if (kill_i) state_d = StDrain;
      end
      StDrain: if (timeout || full) state_d = StIdle;
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    miss_ready_o    = (state_q == StIdle);
    mem_req_valid_o = (state_q == StReq);
    err_o           = timeout || dup;
    fill.valid      = (state_q == StFill);
    fill.addr       = fill_addr_q;
    fill.data       = fill_data_q;
  end

  assign mem_req_addr_o = line_addr_q;
  assign fill_valid_o   = fill.valid;
  assign fill_addr_o    = fill.addr;
  assign fill_data_o    = fill.data;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)          cnt_d = '0;
    else if (collecting) cnt_d = beat ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q       <= '0;
      line_addr_q <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) line_addr_q <= miss_addr_i[31:6];
      // Capture on entry to FILL so the outputs hold while the next refill collects.
      if (state_q == StWait && state_d == StFill) begin
        fill_addr_q <= line_addr_q;
        fill_data_q <= line;
      end
    end
  end

endmodule

// File: tb/tb_imem_refill_initiator.sv
module tb_imem_refill_initiator;

  logic         clk = 1'b0;
  logic         rstn;
  logic         miss_valid;
  logic [39:0]  miss_addr;
  logic         miss_ready;
  logic         kill;
  logic         req_valid;
  logic [25:0]  req_addr;
  logic         rv;
  logic [127:0] rdata;
  logic [1:0]   rseq;
  logic         fill_valid;
  logic [25:0]  fill_addr;
  logic [511:0] fill_data;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_refill_initiator dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .miss_valid_i     (miss_valid),
    .miss_addr_i      (miss_addr),
    .miss_ready_o     (miss_ready),
    .kill_i           (kill),
    .mem_req_valid_o  (req_valid),
    .mem_req_addr_o   (req_addr),
    .mem_resp_valid_i (rv),
    .mem_resp_data_i  (rdata),
    .mem_resp_seq_i   (rseq),
    .fill_valid_o     (fill_valid),
    .fill_addr_o      (fill_addr),
    .fill_data_o      (fill_data),
    .err_o            (err)
  );

  typedef struct packed {
    logic        mv;
    logic [39:0] ma;
    logic        kl;
    logic        rv;
    logic [1:0]  rs;
    logic [7:0]  rtag;
    logic        e_ready;
    logic        e_req;
    logic [25:0] e_req_addr;
    logic        e_fill;
    logic        e_err;
    logic        chk_line;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] bt(input logic [7:0] tag);
    return {16{tag}};
  endfunction

  function automatic logic [511:0] ln(input logic [7:0] t0, input logic [7:0] t1,
                                      input logic [7:0] t2, input logic [7:0] t3);
    return {bt(t3), bt(t2), bt(t1), bt(t0)};
  endfunction

  task automatic idle_in();
    miss_valid = 1'b0;
    kill       = 1'b0;
    rv         = 1'b0;
    rseq       = 2'd0;
    rdata      = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [39:0] addr, input logic [25:0] exp_line);
    idle_in();
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(negedge clk);
    chk("miss_ready_on_accept", miss_ready, 1'b1);
    next();
    idle_in();
    @(negedge clk);
    chk("req_pulse", req_valid, 1'b1);
    chk("req_addr", req_addr, exp_line);
    chk("ready_low_in_req", miss_ready, 1'b0);
    next();
  endtask

  task automatic beat(input logic [1:0] s, input logic [7:0] tag, input logic e_err,
                      input logic k);
    idle_in();
    rv    = 1'b1;
    rseq  = s;
    rdata = bt(tag);
    kill  = k;
    @(negedge clk);
    chk("beat_err", err, e_err);
    chk("beat_no_fill", fill_valid, 1'b0);
    chk("beat_no_req", req_valid, 1'b0);
    next();
    idle_in();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gap_err", err, 1'b0);
      chk("gap_fill", fill_valid, 1'b0);
      next();
    end
  endtask

  task automatic expect_fill(input logic [25:0] addr, input logic [511:0] data);
    @(negedge clk);
    chk("fill_valid", fill_valid, 1'b1);
    chk("fill_addr", fill_addr, addr);
    chk("fill_data", fill_data, data);
    chk("fill_err", err, 1'b0);
    next();
    @(negedge clk);
    chk("fill_one_cycle", fill_valid, 1'b0);
    chk("ready_after_fill", miss_ready, 1'b1);
    chk("fill_data_hold", fill_data, data);
    next();
  endtask

  initial begin
    //          mv    ma           kl    rv    rs    tag    rdy   req   raddr    fill  err   line
    vecs[0] = '{1'b1, 40'h1240,    1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 26'h0,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 40'h0,       1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 26'h49,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 40'h0,       1'b0, 1'b1, 2'd0, 8'hA0, 1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 40'h0,       1'b0, 1'b1, 2'd1, 8'hA1, 1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 40'h0,       1'b0, 1'b1, 2'd2, 8'hA2, 1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 40'h0,       1'b0, 1'b1, 2'd3, 8'hA3, 1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 40'h0,       1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 26'h0,   1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 40'h0,       1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 26'h0,   1'b0, 1'b0, 1'b1};

    // Reset state
    rstn      = 1'b0;
    miss_addr = '0;
    idle_in();
    next();
    next();
    @(negedge clk);
    chk("rst_ready", miss_ready, 1'b1);
    chk("rst_req", req_valid, 1'b0);
    chk("rst_fill", fill_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_fill_addr", fill_addr, 26'h0);
    chk("rst_fill_data", fill_data, 512'h0);
    rstn = 1'b1;
    next();

    // Basic in-order refill, table driven
    for (int i = 0; i < 8; i++) begin
      miss_valid = vecs[i].mv;
      miss_addr  = vecs[i].ma;
      kill       = vecs[i].kl;
      rv         = vecs[i].rv;
      rseq       = vecs[i].rs;
      rdata      = bt(vecs[i].rtag);
      @(negedge clk);
      chk("vec_ready", miss_ready, vecs[i].e_ready);
      chk("vec_req", req_valid, vecs[i].e_req);
      if (vecs[i].e_req) chk("vec_req_addr", req_addr, vecs[i].e_req_addr);
      chk("vec_fill", fill_valid, vecs[i].e_fill);
      chk("vec_err", err, vecs[i].e_err);
      if (vecs[i].chk_line) begin
        chk("vec_fill_addr", fill_addr, 26'h49);
        chk("vec_fill_data", fill_data, ln(8'hA0, 8'hA1, 8'hA2, 8'hA3));
      end
      next();
    end
    idle_in();

    // Out-of-order, gapped beats; upper address bits must be dropped
    miss(40'hFF_1234_5680, 26'h48D15A);
    gap(5); beat(2'd2, 8'hA2, 1'b0, 1'b0);
    gap(5); beat(2'd0, 8'hA0, 1'b0, 1'b0);
    gap(5); beat(2'd3, 8'hA3, 1'b0, 1'b0);
    gap(5); beat(2'd1, 8'hA1, 1'b0, 1'b0);
    expect_fill(26'h48D15A, ln(8'hA0, 8'hA1, 8'hA2, 8'hA3));

    // Duplicate beat: error pulse, first data kept
    miss(40'h1240, 26'h49);
    beat(2'd0, 8'hA0, 1'b0, 1'b0);
    beat(2'd0, 8'h55, 1'b1, 1'b0);
    beat(2'd1, 8'hA1, 1'b0, 1'b0);
    beat(2'd2, 8'hA2, 1'b0, 1'b0);
    beat(2'd3, 8'hA3, 1'b0, 1'b0);
    expect_fill(26'h49, ln(8'hA0, 8'hA1, 8'hA2, 8'hA3));

    // Kill together with the second beat; that beat still counts toward the drain
    miss(40'h2000, 26'h80);
    beat(2'd0, 8'hB0, 1'b0, 1'b0);
    beat(2'd1, 8'hB1, 1'b0, 1'b1);
    beat(2'd2, 8'hB2, 1'b0, 1'b0);
    beat(2'd3, 8'hB3, 1'b0, 1'b0);
    @(negedge clk);
    chk("kill_ready", miss_ready, 1'b1);
    chk("kill_no_fill", fill_valid, 1'b0);
    chk("kill_hold_addr", fill_addr, 26'h49);
    chk("kill_hold_data", fill_data, ln(8'hA0, 8'hA1, 8'hA2, 8'hA3));
    next();
    miss(40'h2000, 26'h80);
    beat(2'd3, 8'hC3, 1'b0, 1'b0);
    beat(2'd2, 8'hC2, 1'b0, 1'b0);
    beat(2'd1, 8'hC1, 1'b0, 1'b0);
    beat(2'd0, 8'hC0, 1'b0, 1'b0);
    expect_fill(26'h80, ln(8'hC0, 8'hC1, 8'hC2, 8'hC3));

    // Timeout after 64 beat-less cycles
    miss(40'h1240, 26'h49);
    gap(63);
    @(negedge clk);
    chk("timeout_err", err, 1'b1);
    chk("timeout_no_fill", fill_valid, 1'b0);
    next();
    @(negedge clk);
    chk("timeout_idle", miss_ready, 1'b1);
    chk("timeout_err_once", err, 1'b0);
    next();
    rv    = 1'b1;
    rseq  = 2'd0;
    rdata = bt(8'hD0);
    @(negedge clk);
    chk("idle_beat_err", err, 1'b0);
    chk("idle_beat_ready", miss_ready, 1'b1);
    next();
    idle_in();
    @(negedge clk);
    chk("idle_beat_ignored", miss_ready, 1'b1);
    chk("idle_beat_no_fill", fill_valid, 1'b0);
    next();

    // Reset in the middle of WAIT
    miss(40'h1240, 26'h49);
    beat(2'd0, 8'hE0, 1'b0, 1'b0);
    rstn = 1'b0;
    next();
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", miss_ready, 1'b1);
    chk("mid_rst_req", req_valid, 1'b0);
    chk("mid_rst_fill", fill_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_fill_addr", fill_addr, 26'h0);
    chk("mid_rst_fill_data", fill_data, 512'h0);
    next();
    miss(40'h1240, 26'h49);
    beat(2'd1, 8'hF1, 1'b0, 1'b0);
    beat(2'd0, 8'hF0, 1'b0, 1'b0);
    beat(2'd2, 8'hF2, 1'b0, 1'b0);
    beat(2'd3, 8'hF3, 1'b0, 1'b0);
    expect_fill(26'h49, ln(8'hF0, 8'hF1, 8'hF2, 8'hF3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
